ddr_wr_sched: RTL and testbench
===============================

DDR_WR_SCHED -- requirements
Module: ddr_wr_sched

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 8: maximum write commands issued per grant (range 1-255).
REQ-002 The block SHALL have parameter VALID_TO, default 8: cycles allowed for FIFO valid after a read, before error (range 2-255).
REQ-003 The block SHALL have port ddr_clk, in, 1: the only clock; all logic on its rising edge.
REQ-004 The block SHALL have port sys_rst, in, 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port phy_init_done_i, in, 1: DDR PHY calibration complete, already synchronous to ddr_clk.
REQ-006 The block SHALL have port wr_grant_i, in, 1: write ownership of the DDR app port, from the top-level read/write arbiter.
REQ-007 The block SHALL have port wr_req_o, out, 1: a write transaction is eligible.
REQ-008 The block SHALL have port wr_addr_fifo_rd_en, out, 1: pop the address FIFO.
REQ-009 The block SHALL have port wr_addr_fifo_data_out, in, 30: address FIFO data.
REQ-010 The block SHALL have port wr_addr_fifo_valid, in, 1: address data valid, one or more cycles after rd_en.
REQ-011 The block SHALL have port wr_addr_fifo_empty, in, 1: address FIFO empty.
REQ-012 The block SHALL have port wr_ddr_fifo_rd_en, out, 1: pop one 256-bit data beat.
REQ-013 The block SHALL have port wr_ddr_fifo_data_out, in, 256: data beat.
REQ-014 The block SHALL have port wr_ddr_fifo_valid, in, 1: data beat valid.
REQ-015 The block SHALL have port wr_ddr_fifo_rd_count, in, 9: beats available.
REQ-016 The block SHALL have port app_en, out, 1: MIG command strobe.
REQ-017 The block SHALL have port app_cmd, out, 3: MIG command; always 3'b000 (write).
REQ-018 The block SHALL have port app_addr, out, 30: MIG address.
REQ-019 The block SHALL have port app_rdy, in, 1: MIG command accepted.
REQ-020 The block SHALL have port app_wdf_wren / app_wdf_data / app_wdf_end, out, 1/256/1: MIG write-data strobe, beat and last-beat flag.
REQ-021 The block SHALL have port app_wdf_rdy, in, 1: MIG write-data accepted.
REQ-022 The block SHALL have port wr_err_o, out, 1: sticky FIFO-valid timeout flag.

Function
REQ-023 One transaction SHALL be 1 address plus 2 data beats (one 512-bit FIFO entry); eligible = phy_init_done_i & !wr_addr_fifo_empty & wr_ddr_fifo_rd_count>=2.
REQ-024 wr_req_o SHALL be registered eligibility, updated every cycle, forced 0 while FSM is not IDLE.
REQ-025 FSM states SHALL be IDLE, POP, LD0, LD1, WDF0, WDF1, CMD; all outputs SHALL be registered or decoded from state only.
REQ-026 IDLE->POP when eligible & wr_grant_i, otherwise stay; burst_cnt cleared on entering POP from IDLE.
REQ-027 POP SHALL assert wr_addr_fifo_rd_en and wr_ddr_fifo_rd_en for exactly 1 cycle, then go to LD0.
REQ-028 LD0 SHALL capture address and beat0 independently on their valid; once both captured, pulse wr_ddr_fifo_rd_en for 1 cycle and go to LD1.
REQ-029 LD1 SHALL capture beat1 on wr_ddr_fifo_valid and go to WDF0.
REQ-030 WDF0 SHALL drive app_wdf_wren=1, app_wdf_data=beat0, app_wdf_end=0 until app_wdf_rdy=1; then go to WDF1.
REQ-031 WDF1 SHALL drive app_wdf_wren=1, app_wdf_data=beat1, app_wdf_end=1 until app_wdf_rdy=1; then go to CMD.
REQ-032 CMD SHALL drive app_en=1, app_cmd=000, app_addr=captured address until app_rdy=1; on acceptance burst_cnt increments (8-bit).
REQ-033 After CMD acceptance the FSM SHALL go to POP if eligible & wr_grant_i & burst_cnt<MAX_BURST, else IDLE; grant-to-first-rd_en latency is 1 cycle.
REQ-034 Under backpressure, all app_* outputs SHALL stay stable until accepted.
REQ-035 Deassertion of wr_grant_i or phy_init_done_i mid-transaction SHALL NOT abort; the current transaction completes, then IDLE.
REQ-036 In LD0/LD1 a counter SHALL count cycles waiting for valid; when it reaches VALID_TO, set wr_err_o=1 (sticky until reset) and go to IDLE without issuing.
REQ-037 Outside reset, rd_en SHALL never be asserted when the FIFOs are empty.

Reset
REQ-038 On sys_rst=1, immediately and asynchronously: FSM=IDLE; every output=0 except app_cmd=000; counters and capture registers=0. FIFO contents are not flushed; a mid-transaction reset drops that transaction.

Verification
REQ-039 Grant held, 1 entry (addr 0x100, beats A/B), rdy lines tied 1: rd_en@+1; wdf A end0, wdf B end1, app_en addr 0x100; wr_err_o=0.
REQ-040 10 entries queued, grant held, MAX_BURST=8: exactly 8 app_en acceptances, then IDLE; wr_req_o=1 again with 2 entries left.
REQ-041 app_wdf_rdy=0 for 5 cycles in WDF1, then app_rdy=0 for 3 cycles in CMD: outputs stable throughout; exactly 1 command issued.
REQ-042 wr_ddr_fifo_valid never asserts after POP, VALID_TO=8: wr_err_o=1 after 8 cycles; FSM IDLE; no app_en.
REQ-043 Grant drops in WDF0: transaction completes; no further POP. sys_rst pulse in WDF1: all outputs 0 same cycle.
REQ-044 rd_count=1 with address FIFO non-empty and phy_init_done_i=1: wr_req_o=0 and no rd_en.

Source files
------------

// File: rtl/ddr_wr_sched.sv
// DDR write scheduler: pops one address + two 256-bit beats per transaction
// and hands them to the MIG write-data and command ports in bursts.
module ddr_wr_sched #(
    parameter int MAX_BURST = 8,
    parameter int VALID_TO  = 8
) (
    input  logic         ddr_clk,
    input  logic         sys_rst,
    input  logic         phy_init_done_i,
    input  logic         wr_grant_i,
    output logic         wr_req_o,
    output logic         wr_addr_fifo_rd_en,
    input  logic [29:0]  wr_addr_fifo_data_out,
    input  logic         wr_addr_fifo_valid,
    input  logic         wr_addr_fifo_empty,
    output logic         wr_ddr_fifo_rd_en,
    input  logic [255:0] wr_ddr_fifo_data_out,
    input  logic         wr_ddr_fifo_valid,
    input  logic [8:0]   wr_ddr_fifo_rd_count,
    output logic         app_en,
    output logic [2:0]   app_cmd,
    output logic [29:0]  app_addr,
    input  logic         app_rdy,
    output logic         app_wdf_wren,
    output logic [255:0] app_wdf_data,
    output logic         app_wdf_end,
    input  logic         app_wdf_rdy,
    output logic         wr_err_o
);

    typedef enum logic [2:0] {
        IDLE, POP, LD0, LD1, WDF0, WDF1, CMD
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(VALID_TO - 1);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    state_t        state, state_n;
    logic [7:0]    burst_cnt, burst_n, wait_cnt;
    logic [29:0]   addr_q;
    logic [255:0]  beat0_q, beat1_q;
    logic          have_addr, have_beat0;
    logic          pop2, wr_req_q, err_q;
    logic          eligible, addr_ok, beat0_ok, timeout, loading;

    assign eligible = phy_init_done_i & ~wr_addr_fifo_empty
                    & (wr_ddr_fifo_rd_count >= 9'd2);
    assign addr_ok  = have_addr | wr_addr_fifo_valid;
    assign beat0_ok = have_beat0 | wr_ddr_fifo_valid;
    assign timeout  = (wait_cnt == TO_LAST);
    assign burst_n  = burst_cnt + 8'd1;
    assign loading  = (state == LD0) | (state == LD1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (eligible & wr_grant_i) state_n = POP;
            POP:  state_n = LD0;
            LD0: begin
                if (addr_ok & beat0_ok) state_n = LD1;
                else if (timeout)       state_n = IDLE;
            end
            LD1: begin
                if (wr_ddr_fifo_valid)  state_n = WDF0;
                else if (timeout)       state_n = IDLE;
            end
            WDF0: if (app_wdf_rdy) state_n = WDF1;
            WDF1: if (app_wdf_rdy) state_n = CMD;
            CMD: begin
                if (app_rdy)
                    state_n = (eligible & wr_grant_i & (burst_n < BURST_MAX))
                            ? POP : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            wait_cnt   <= '0;
            addr_q     <= '0;
            beat0_q    <= '0;
            beat1_q    <= '0;
            have_addr  <= 1'b0;
            have_beat0 <= 1'b0;
            pop2       <= 1'b0;
            wr_req_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state    <= state_n;
            wr_req_q <= eligible & (state_n == IDLE);
            // second beat is popped only once the first one has landed
            pop2     <= (state == LD0) & (state_n == LD1);
            if (state == IDLE && state_n == POP)
                burst_cnt <= '0;
            else if (state == CMD && app_rdy)
                burst_cnt <= burst_n;
            if (loading && state_n == state)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= '0;
            if (loading && state_n == IDLE)
                err_q <= 1'b1;
            if (state == POP) begin
                have_addr  <= 1'b0;
                have_beat0 <= 1'b0;
            end
            if (state == LD0) begin
                if (wr_addr_fifo_valid && !have_addr) begin
                    addr_q    <= wr_addr_fifo_data_out;
                    have_addr <= 1'b1;
                end
                if (wr_ddr_fifo_valid && !have_beat0) begin
                    beat0_q    <= wr_ddr_fifo_data_out;
                    have_beat0 <= 1'b1;
                end
            end
            if (state == LD1 && wr_ddr_fifo_valid)
                beat1_q <= wr_ddr_fifo_data_out;
        end
    end

    assign wr_req_o           = wr_req_q;
    assign wr_addr_fifo_rd_en = (state == POP);
    assign wr_ddr_fifo_rd_en  = (state == POP) | pop2;
    assign app_en             = (state == CMD);
    assign app_cmd            = 3'b000;
    assign app_addr           = (state == CMD) ? addr_q : '0;
    assign app_wdf_wren       = (state == WDF0) | (state == WDF1);
    assign app_wdf_end        = (state == WDF1);
    assign app_wdf_data       = (state == WDF0) ? beat0_q
                              : (state == WDF1) ? beat1_q : '0;
    assign wr_err_o           = err_q;

endmodule

// File: tb/tb_ddr_wr_sched.sv
// Directed bench for ddr_wr_sched with a small address/data FIFO model.
module tb_ddr_wr_sched;

    logic         ddr_clk = 1'b0;
    logic         sys_rst;
    logic         phy_init_done_i, wr_grant_i, wr_req_o;
    logic         wr_addr_fifo_rd_en, wr_addr_fifo_valid, wr_addr_fifo_empty;
    logic [29:0]  wr_addr_fifo_data_out;
    logic         wr_ddr_fifo_rd_en, wr_ddr_fifo_valid;
    logic [255:0] wr_ddr_fifo_data_out;
    logic [8:0]   wr_ddr_fifo_rd_count;
    logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [2:0]   app_cmd;
    logic [29:0]  app_addr;
    logic [255:0] app_wdf_data;
    logic         wr_err_o;

    int tests = 0;
    int fails = 0;

    logic [29:0]  amem [0:63];
    logic [255:0] dmem [0:127];
    int awp = 0, arp = 0, dwp = 0, drp = 0;
    logic kill = 1'b0, flush = 1'b0;
    int viol = 0;

    int cmd_n = 0, wdf_n = 0, rd_n = 0;
    logic [29:0]  last_addr = '0;
    logic [255:0] wdf_d [0:15];
    logic         wdf_e [0:15];
    logic [39:0]  outs;

    always #5 ddr_clk = ~ddr_clk;

    ddr_wr_sched #(.MAX_BURST(8), .VALID_TO(8)) dut (
        .ddr_clk(ddr_clk), .sys_rst(sys_rst),
        .phy_init_done_i(phy_init_done_i), .wr_grant_i(wr_grant_i),
        .wr_req_o(wr_req_o),
        .wr_addr_fifo_rd_en(wr_addr_fifo_rd_en),
        .wr_addr_fifo_data_out(wr_addr_fifo_data_out),
        .wr_addr_fifo_valid(wr_addr_fifo_valid),
        .wr_addr_fifo_empty(wr_addr_fifo_empty),
        .wr_ddr_fifo_rd_en(wr_ddr_fifo_rd_en),
        .wr_ddr_fifo_data_out(wr_ddr_fifo_data_out),
        .wr_ddr_fifo_valid(wr_ddr_fifo_valid),
        .wr_ddr_fifo_rd_count(wr_ddr_fifo_rd_count),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_rdy(app_rdy), .app_wdf_wren(app_wdf_wren),
        .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .wr_err_o(wr_err_o)
    );

    assign wr_addr_fifo_empty   = (awp == arp);
    assign wr_ddr_fifo_rd_count = 9'(dwp - drp);
    assign outs = {wr_req_o, wr_addr_fifo_rd_en, wr_ddr_fifo_rd_en, app_en,
                   app_cmd, app_addr, app_wdf_wren, app_wdf_end, wr_err_o};

    // FIFO model: one cycle read latency, optional suppression of data valid
    always @(posedge ddr_clk) begin
        wr_addr_fifo_valid <= 1'b0;
        wr_ddr_fifo_valid  <= 1'b0;
        if (flush) begin
            arp <= awp;
            drp <= dwp;
        end else begin
            if (wr_addr_fifo_rd_en) begin
                if (arp == awp) viol <= viol + 1;
                else begin
                    wr_addr_fifo_data_out <= amem[arp[5:0]];
                    wr_addr_fifo_valid    <= 1'b1;
                    arp <= arp + 1;
                end
            end
            if (wr_ddr_fifo_rd_en) begin
                if (drp == dwp) viol <= viol + 1;
                else begin
                    wr_ddr_fifo_data_out <= dmem[drp[6:0]];
                    wr_ddr_fifo_valid    <= ~kill;
                    drp <= drp + 1;
                end
            end
        end
    end

    always @(posedge ddr_clk) begin
        if (!sys_rst) begin
            if (app_en && app_rdy) begin
                cmd_n     <= cmd_n + 1;
                last_addr <= app_addr;
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                wdf_d[wdf_n[3:0]] <= app_wdf_data;
                wdf_e[wdf_n[3:0]] <= app_wdf_end;
                wdf_n <= wdf_n + 1;
            end
            if (wr_addr_fifo_rd_en) rd_n <= rd_n + 1;
        end
    end

    function automatic logic [255:0] beat(input int k);
        logic [31:0] w;
        w = 32'(k) ^ 32'hA5A5_0000;
        return {8{w}};
    endfunction

    task automatic chk(input string tag, input logic [299:0] obs,
                       input logic [299:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_addr(input logic [29:0] a);
        amem[awp[5:0]] = a;
        awp++;
    endtask

    task automatic push_beat(input int k);
        dmem[dwp[6:0]] = beat(k);
        dwp++;
    endtask

    task automatic push_entry(input logic [29:0] a, input int k);
        push_addr(a);
        push_beat(2 * k);
        push_beat(2 * k + 1);
    endtask

    task automatic wait_cmd(input string tag, input int target);
        int n = 0;
        while (cmd_n < target && n < 400) begin
            @(negedge ddr_clk);
            n++;
        end
        chk(tag, 300'(cmd_n), 300'(target));
    endtask

    task automatic wait_wdf0(input string tag);
        int n = 0;
        while (!(app_wdf_wren && !app_wdf_end) && n < 50) begin
            @(negedge ddr_clk);
            n++;
        end
        chk(tag, 300'(app_wdf_wren & ~app_wdf_end), 300'd1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge ddr_clk);
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rbase, n;
        sys_rst = 1'b1;
        phy_init_done_i = 1'b0;
        wr_grant_i = 1'b0;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        repeat (2) @(negedge ddr_clk);
        chk("rst_outs", 300'(outs), 300'd0);
        chk("rst_wdf_data", 300'(app_wdf_data), 300'd0);
        sys_rst = 1'b0;
        @(negedge ddr_clk);

        // single transaction, all ready lines high
        push_entry(30'h100, 0);
        phy_init_done_i = 1'b1;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        wr_grant_i = 1'b1;
        chk("pre_grant_rd_en", 300'({wr_addr_fifo_rd_en, wr_ddr_fifo_rd_en}), 300'd0);
        @(posedge ddr_clk);
        #1;
        chk("grant_rd_en_lat", 300'({wr_addr_fifo_rd_en, wr_ddr_fifo_rd_en}), 300'b11);
        wait_cmd("single_cmd", 1);
        chk("single_wdf_cnt", 300'(wdf_n), 300'd2);
        chk("single_beat0", 300'({wdf_e[0], wdf_d[0]}), 300'({1'b0, beat(0)}));
        chk("single_beat1", 300'({wdf_e[1], wdf_d[1]}), 300'({1'b1, beat(1)}));
        chk("single_addr", 300'(last_addr), 300'h100);
        chk("single_err", 300'(wr_err_o), 300'd0);
        wr_grant_i = 1'b0;
        repeat (3) @(negedge ddr_clk);

        // ten entries, burst limit of eight
        base = cmd_n;
        for (int i = 1; i <= 10; i++) push_entry(30'h200 + 30'(i - 1), i);
        wr_grant_i = 1'b1;
        wait_cmd("burst_reach8", base + 8);
        wr_grant_i = 1'b0;
        chk("burst_req_idle", 300'(wr_req_o), 300'd1);
        chk("burst_last_addr", 300'(last_addr), 300'h207);
        repeat (10) @(negedge ddr_clk);
        chk("burst_exact8", 300'(cmd_n - base), 300'd8);
        chk("burst_left_addr", 300'(awp - arp), 300'd2);
        chk("burst_left_data", 300'(dwp - drp), 300'd4);
        chk("burst_req_hold", 300'(wr_req_o), 300'd1);
        wr_grant_i = 1'b1;
        wait_cmd("burst_drain", base + 10);
        wr_grant_i = 1'b0;
        chk("burst_drain_addr", 300'(last_addr), 300'h209);
        repeat (3) @(negedge ddr_clk);

        // back-pressure in WDF1 then CMD
        base = cmd_n;
        n = wdf_n;
        app_wdf_rdy = 1'b0;
        app_rdy = 1'b0;
        push_entry(30'h300, 20);
        wr_grant_i = 1'b1;
        wait_wdf0("bp_reach_wdf0");
        app_wdf_rdy = 1'b1;
        @(negedge ddr_clk);
        app_wdf_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_wdf1_hold",
                300'({app_wdf_wren, app_wdf_end, app_en, app_wdf_data}),
                300'({1'b1, 1'b1, 1'b0, beat(41)}));
            @(negedge ddr_clk);
        end
        app_wdf_rdy = 1'b1;
        @(negedge ddr_clk);
        app_wdf_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_cmd_hold",
                300'({app_en, app_cmd, app_addr, app_wdf_wren}),
                300'({1'b1, 3'b000, 30'h300, 1'b0}));
            @(negedge ddr_clk);
        end
        app_rdy = 1'b1;
        repeat (6) @(negedge ddr_clk);
        chk("bp_one_cmd", 300'(cmd_n - base), 300'd1);
        chk("bp_two_wdf", 300'(wdf_n - n), 300'd2);
        wr_grant_i = 1'b0;
        app_wdf_rdy = 1'b1;
        repeat (2) @(negedge ddr_clk);

        // data valid never arrives
        base = cmd_n;
        do_flush();
        kill = 1'b1;
        push_entry(30'h400, 30);
        wr_grant_i = 1'b1;
        n = 0;
        while (!wr_addr_fifo_rd_en && n < 10) begin
            @(negedge ddr_clk);
            n++;
        end
        chk("to_pop_seen", 300'(wr_addr_fifo_rd_en), 300'd1);
        repeat (8) @(negedge ddr_clk);
        chk("to_err_before", 300'(wr_err_o), 300'd0);
        @(negedge ddr_clk);
        chk("to_err_set", 300'(wr_err_o), 300'd1);
        repeat (5) @(negedge ddr_clk);
        chk("to_err_sticky", 300'(wr_err_o), 300'd1);
        chk("to_no_cmd", 300'(cmd_n - base), 300'd0);
        chk("to_idle_quiet", 300'({app_en, app_wdf_wren}), 300'd0);
        wr_grant_i = 1'b0;
        kill = 1'b0;
        sys_rst = 1'b1;
        #1;
        chk("to_err_rst", 300'(wr_err_o), 300'd0);
        @(negedge ddr_clk);
        sys_rst = 1'b0;
        do_flush();

        // grant drops during WDF0
        base = cmd_n;
        rbase = rd_n;
        app_wdf_rdy = 1'b0;
        push_entry(30'h500, 40);
        push_entry(30'h501, 41);
        wr_grant_i = 1'b1;
        wait_wdf0("gd_reach_wdf0");
        wr_grant_i = 1'b0;
        app_wdf_rdy = 1'b1;
        wait_cmd("gd_completes", base + 1);
        repeat (10) @(negedge ddr_clk);
        chk("gd_one_cmd", 300'(cmd_n - base), 300'd1);
        chk("gd_addr", 300'(last_addr), 300'h500);
        chk("gd_one_pop", 300'(rd_n - rbase), 300'd1);
        chk("gd_req_idle", 300'(wr_req_o), 300'd1);

        // reset pulse while in WDF1
        app_wdf_rdy = 1'b0;
        wr_grant_i = 1'b1;
        wait_wdf0("rp_reach_wdf0");
        app_wdf_rdy = 1'b1;
        @(negedge ddr_clk);
        app_wdf_rdy = 1'b0;
        chk("rp_in_wdf1", 300'({app_wdf_wren, app_wdf_end}), 300'b11);
        sys_rst = 1'b1;
        #1;
        chk("rp_outs_zero", 300'(outs), 300'd0);
        chk("rp_data_zero", 300'(app_wdf_data), 300'd0);
        @(negedge ddr_clk);
        wr_grant_i = 1'b0;
        sys_rst = 1'b0;
        app_wdf_rdy = 1'b1;
        do_flush();

        // only one data beat available
        rbase = rd_n;
        push_addr(30'h600);
        push_beat(100);
        wr_grant_i = 1'b1;
        repeat (6) @(negedge ddr_clk);
        chk("cnt1_no_req", 300'(wr_req_o), 300'd0);
        chk("cnt1_no_pop", 300'(rd_n - rbase), 300'd0);
        phy_init_done_i = 1'b0;
        push_beat(101);
        repeat (4) @(negedge ddr_clk);
        chk("nophy_no_req", 300'(wr_req_o), 300'd0);
        chk("nophy_no_pop", 300'(rd_n - rbase), 300'd0);
        wr_grant_i = 1'b0;
        phy_init_done_i = 1'b1;
        repeat (2) @(negedge ddr_clk);
        chk("elig_req", 300'(wr_req_o), 300'd1);
        chk("no_empty_pops", 300'(viol), 300'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
